// File: rtl/spi_register_bank_pkg.sv
// Shared types and default opcodes for the SPI-addressed byte register bank.
package spi_register_bank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA
  } state_e;

  localparam logic [7:0] WRITE_OPCODE_DEF = 8'h40;
  localparam logic [7:0] READ_OPCODE_DEF  = 8'h41;
  localparam logic [7:0] RESET_VALUE_DEF  = 8'h00;

endpackage

// File: rtl/spi_register_bank.sv
// Byte register bank on the spi_peripheral opcode/operand bus: burst write and
// burst read with auto-incrementing pointer, every register exported to fabric.
//
// state   | meaning
// IDLE    | no transaction of ours; response not driven
// WR_ADDR | write burst, waiting for the start address
// WR_DATA | write burst, each operand written at pointer then pointer++
// RD_ADDR | read burst, waiting for the start address (response = 0)
// RD_DATA | read burst, response = bank[pointer], pointer++ per operand
module spi_register_bank
  import spi_register_bank_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter logic [7:0] WRITE_OPCODE = WRITE_OPCODE_DEF,
  parameter logic [7:0] READ_OPCODE  = READ_OPCODE_DEF,
  parameter logic [7:0] RESET_VALUE  = RESET_VALUE_DEF
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic [7:0]                 opcode_in,
  input  logic                       opcode_valid_in,
  input  logic [7:0]                 operand_in,
  input  logic                       operand_valid_in,
  input  logic [31:0]                operand_count_in,
  output logic [7:0]                 response_out,
  output logic                       response_valid_out,
  output logic [DEPTH*8-1:0]         registers_out,
  output logic                       write_strobe_out,
  output logic [$clog2(DEPTH)-1:0]   write_address_out
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [7:0]      bank_q [DEPTH];
  logic            operand_valid_q;
  logic            op_pulse;
  logic            wr_en;
  logic [7:0]      response_d;
  logic            response_valid_d;

  assign op_pulse = operand_valid_in & ~operand_valid_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    // Dropping opcode_valid_in wins over a coincident operand pulse.
    if (!opcode_valid_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (opcode_in == WRITE_OPCODE)     state_d = WR_ADDR;
          else if (opcode_in == READ_OPCODE) state_d = RD_ADDR;
        end
        WR_ADDR: if (op_pulse) begin
          ptr_d   = operand_in[AW-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: if (op_pulse) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
        end
        RD_ADDR: if (op_pulse) begin
          ptr_d   = operand_in[AW-1:0];
          state_d = RD_DATA;
        end
        RD_DATA: if (op_pulse) ptr_d = ptr_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    response_valid_d = (state_d == RD_ADDR) || (state_d == RD_DATA);
    response_d       = (state_d == RD_DATA) ? bank_q[ptr_d] : 8'h00;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      operand_valid_q    <= 1'b0;
      response_out       <= 8'h00;
      response_valid_out <= 1'b0;
      write_strobe_out   <= 1'b0;
      write_address_out  <= '0;
      for (int k = 0; k < DEPTH; k++) bank_q[k] <= RESET_VALUE;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      operand_valid_q    <= operand_valid_in;
      response_out       <= response_d;
      response_valid_out <= response_valid_d;
      write_strobe_out   <= wr_en;
      if (wr_en) begin
        bank_q[ptr_q]     <= operand_in;
        write_address_out <= ptr_q;
      end
    end
  end

  always_comb begin
    registers_out = '0;
    for (int k = 0; k < DEPTH; k++) registers_out[8*k +: 8] = bank_q[k];
  end

  // Simulation check: the first operand of every transaction must be index 0.
  logic first_pulse_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in)              first_pulse_q <= 1'b1;
    else if (!opcode_valid_in) first_pulse_q <= 1'b1;
    else if (op_pulse)         first_pulse_q <= 1'b0;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in && opcode_valid_in && op_pulse && first_pulse_q)
      assert (operand_count_in == 32'd0);
  end

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed and randomized bursts against an array model of the register bank.
module tb_spi_register_bank;
  import spi_register_bank_pkg::*;

  localparam int DEPTH = 16;

  logic                 clock_in = 1'b0;
  logic                 reset_in;
  logic [7:0]           opcode_in;
  logic                 opcode_valid_in;
  logic [7:0]           operand_in;
  logic                 operand_valid_in;
  logic [31:0]          operand_count_in;
  logic [7:0]           response_out;
  logic                 response_valid_out;
  logic [DEPTH*8-1:0]   registers_out;
  logic                 write_strobe_out;
  logic [3:0]           write_address_out;

  spi_register_bank #(.DEPTH(DEPTH)) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .opcode_in(opcode_in), .opcode_valid_in(opcode_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in),
    .operand_count_in(operand_count_in),
    .response_out(response_out), .response_valid_out(response_valid_out),
    .registers_out(registers_out), .write_strobe_out(write_strobe_out),
    .write_address_out(write_address_out)
  );

  always #5 clock_in = ~clock_in;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model [DEPTH];
  int         op_idx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] v = '0;
    for (int k = 0; k < DEPTH; k++) v[8*k +: 8] = model[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic start(input logic [7:0] op);
    opcode_in       = op;
    opcode_valid_in = 1'b1;
    op_idx          = 0;
    tick();
  endtask

  task automatic pulse(input logic [7:0] b);
    operand_in       = b;
    operand_count_in = op_idx;
    operand_valid_in = 1'b1;
    tick();
    op_idx++;
  endtask

  task automatic release_op();
    operand_valid_in = 1'b0;
    tick();
  endtask

  task automatic stop();
    opcode_valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr_burst(input int addr, input logic [7:0] data [$]);
    int a;
    start(8'h40);
    pulse(addr[7:0]);
    release_op();
    for (int i = 0; i < data.size(); i++) begin
      a = (addr + i) % DEPTH;
      model[a] = data[i];
      pulse(data[i]);
      chk("wr_strobe_hi", {127'd0, write_strobe_out}, 128'd1);
      chk("wr_addr", {124'd0, write_address_out}, a);
      chk("wr_regs", registers_out, model_flat());
      release_op();
      chk("wr_strobe_lo", {127'd0, write_strobe_out}, 128'd0);
    end
    stop();
  endtask

  task automatic rd_burst(input int addr, input int n);
    start(8'h41);
    chk("rd_valid_addr", {127'd0, response_valid_out}, 128'd1);
    chk("rd_resp_addr", {120'd0, response_out}, 128'd0);
    for (int i = 0; i < n; i++) begin
      pulse(i == 0 ? addr[7:0] : 8'($urandom));
      chk("rd_resp", {120'd0, response_out}, model[(addr + i) % DEPTH]);
      chk("rd_valid", {127'd0, response_valid_out}, 128'd1);
      release_op();
    end
    opcode_valid_in = 1'b0;
    chk("rd_valid_before_fall", {127'd0, response_valid_out}, 128'd1);
    tick();
    chk("rd_valid_fall", {127'd0, response_valid_out}, 128'd0);
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < DEPTH; k++) model[k] = 8'h00;
    chk({tag, "_regs"}, registers_out, 128'd0);
    chk({tag, "_valid"}, {127'd0, response_valid_out}, 128'd0);
    chk({tag, "_strobe"}, {127'd0, write_strobe_out}, 128'd0);
    chk({tag, "_waddr"}, {124'd0, write_address_out}, 128'd0);
    chk({tag, "_resp"}, {120'd0, response_out}, 128'd0);
  endtask

  initial begin
    logic [7:0] q [$];
    int strobes;
    int addr;
    int n;

    reset_in = 1'b1;
    opcode_in = 8'h00; opcode_valid_in = 1'b0;
    operand_in = 8'h00; operand_valid_in = 1'b0; operand_count_in = 32'd0;
    op_idx = 0;
    tick(); tick();
    check_reset_state("por");
    reset_in = 1'b0;
    tick();

    // Directed burst write 3..5
    q = '{8'hAA, 8'hBB, 8'hCC};
    wr_burst(3, q);

    // Preload 15 and 0 through a wrapping write, then wrapping read
    q = '{8'h11, 8'h22};
    wr_burst(15, q);
    rd_burst(15, 3);

    // Address truncation: 0x13 lands on register 3
    q = '{8'h5D};
    wr_burst(8'h13, q);

    // Held operand level must produce exactly one write
    start(8'h40);
    pulse(8'h02);
    release_op();
    operand_in = 8'h5A; operand_count_in = op_idx; operand_valid_in = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_strobe_out) strobes++;
    end
    model[2] = 8'h5A;
    chk("held_strobes", strobes, 128'd1);
    chk("held_regs", registers_out, model_flat());
    release_op();
    stop();

    // Foreign opcode: never owns the response, never writes
    start(8'hDB);
    for (int i = 0; i < 3; i++) begin
      pulse(8'(i + 1));
      chk("foreign_valid", {127'd0, response_valid_out}, 128'd0);
      chk("foreign_strobe", {127'd0, write_strobe_out}, 128'd0);
      release_op();
    end
    chk("foreign_regs", registers_out, model_flat());
    stop();

    // Abort after one data byte, with an opcode change mid-burst ignored
    start(8'h40);
    pulse(8'h09);
    release_op();
    opcode_in = 8'h41;
    model[9] = 8'h3C;
    pulse(8'h3C);
    chk("abort_strobe", {127'd0, write_strobe_out}, 128'd1);
    release_op();
    stop();
    chk("abort_kept", registers_out, model_flat());
    rd_burst(9, 1);

    // Coincident end and pulse: pulse is dropped
    start(8'h40);
    pulse(8'h07);
    release_op();
    opcode_valid_in = 1'b0;
    operand_in = 8'hEE; operand_valid_in = 1'b1;
    tick();
    chk("coinc_strobe", {127'd0, write_strobe_out}, 128'd0);
    tick();
    chk("coinc_regs", registers_out, model_flat());
    operand_valid_in = 1'b0;
    tick();

    // Randomized bursts
    for (int t = 0; t < 24; t++) begin
      addr = $urandom_range(0, 255);
      n    = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        wr_burst(addr, q);
      end else begin
        rd_burst(addr, n);
      end
    end

    // Reset mid-burst clears the whole bank
    start(8'h40);
    pulse(8'h05);
    release_op();
    pulse(8'h77);
    reset_in = 1'b1;
    opcode_valid_in = 1'b0;
    operand_valid_in = 1'b0;
    #2;
    check_reset_state("midrst");
    tick();
    reset_in = 1'b0;
    tick();
    rd_burst(4, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
